mix_column_seq: RTL

Parametrised, handshaked successor to the combinational MixColumns stage. It transforms a 128-bit AES state by MixColumns, or by InvMixColumns when the mode input selects it. The transform is iterative: COLS_PER_CYCLE columns per clock, so the same block serves area-lean and throughput-oriented cipher cores. It sits between ShiftRows and AddRoundKey in the round datapath and uses a valid/ready handshake instead of fixed pipeline timing.

---
 rtl/mix_column_seq_pkg.sv | 34 +++
 rtl/mix_column_seq_if.sv | 20 ++
 rtl/mix_column_seq_core.sv | 30 +++
 rtl/mix_column_seq.sv | 89 ++++++++
 4 files changed

// File: rtl/mix_column_seq_pkg.sv
// mix_column_pkg: GF(2^8) helpers, MixColumns coefficients, FSM states and the
// COLS_PER_CYCLE legality check shared by the iterative MixColumns block.
package mix_column_pkg;

    localparam logic [7:0] GF_POLY = 8'h1b;

    // Circulant row 0; entry k multiplies a[(r+k)%4] for output byte r.
    localparam logic [3:0][7:0] FWD_COEF = {8'h01, 8'h01, 8'h03, 8'h02};
    localparam logic [3:0][7:0] INV_COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // With a constant coefficient this folds to a few xtime stages and XORs.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] coef);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (coef[i]) p = p ^ s;
            s = xtime(s);
        end
        return p;
    endfunction

    function automatic bit cols_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4);
    endfunction

endpackage

// File: rtl/mix_column_seq_if.sv
// Handshake bus for mix_column_seq: input state with mode, and result output.
interface mix_column_seq_if;
    logic         i_Valid;
    logic         o_Ready;
    logic [127:0] i_Data;
    logic         i_Inverse;
    logic         o_Valid;
    logic         i_Ready;
    logic [127:0] o_Data;

    modport slave (
        input  i_Valid, i_Data, i_Inverse, i_Ready,
        output o_Ready, o_Valid, o_Data
    );

    modport master (
        output i_Valid, i_Data, i_Inverse, i_Ready,
        input  o_Ready, o_Valid, o_Data
    );
endinterface

// File: rtl/mix_column_seq_core.sv
// mix_column_core: combinational transform of one 32-bit column.
// Inverse datapath only exists when MIX_COLUMN_INV_EN is defined.
module mix_column_core
    import mix_column_pkg::*;
(
    input  logic [31:0] col,
    input  logic        inv,
    output logic [31:0] res
);

    // Both products are computed from constant coefficients, then muxed,
    // so no general multiplier appears on the column path.
    always_comb begin
        logic [7:0] f;
        logic [7:0] v;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            f = 8'h00;
            v = 8'h00;
            for (int j = 0; j < 4; j++) begin
                f = f ^ gf_mul(col[31-8*j -: 8], FWD_COEF[(j - r + 4) % 4]);
`ifdef MIX_COLUMN_INV_EN
                v = v ^ gf_mul(col[31-8*j -: 8], INV_COEF[(j - r + 4) % 4]);
`endif
            end
            res[31-8*r -: 8] = inv ? v : f;
        end
    end

endmodule

// File: rtl/mix_column_seq.sv
// mix_column_seq: iterative MixColumns / InvMixColumns, COLS_PER_CYCLE columns
// per clock, valid/ready on both sides. Macro MIX_COLUMN_INV_EN builds the
// inverse datapath; without it the mode is tied to forward.
module mix_column_seq
    import mix_column_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    mix_column_seq_if.slave   bus
);

    if (!cols_legal(COLS_PER_CYCLE)) begin : g_bad_cfg
        $error("mix_column_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [2:0] CNT_STEP = 3'(COLS_PER_CYCLE);
    localparam logic [2:0] CNT_LAST = 3'(4 - COLS_PER_CYCLE);

    state_t       state_q, state_d;
    logic [2:0]   cnt;
    logic [127:0] work;
    logic         mode;

    logic [COLS_PER_CYCLE-1:0][31:0] col_in, col_out;

    assign bus.o_Ready = (state_q == IDLE);
    assign bus.o_Valid = (state_q == DONE);
    assign bus.o_Data  = work;

    // Pick the current column group out of the working register.
    always_comb begin
        col_in = '0;
        for (int i = 0; i < COLS_PER_CYCLE; i++)
            col_in[i] = work[127 - 32*(int'(cnt) + i) -: 32];
    end

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
        mix_column_core u_core (
            .col (col_in[i]),
            .inv (mode),
            .res (col_out[i])
        );
    end

    // Next-state logic: accept in IDLE, finish on the group holding column 3.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.i_Valid)     state_d = BUSY;
            BUSY: if (cnt == CNT_LAST) state_d = DONE;
            DONE: if (bus.i_Ready)     state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Working register and column counter: load on accept, update in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work <= '0;
            cnt  <= '0;
        end else if (state_q == IDLE && bus.i_Valid) begin
            work <= bus.i_Data;
            cnt  <= '0;
        end else if (state_q == BUSY) begin
            for (int i = 0; i < COLS_PER_CYCLE; i++)
                work[127 - 32*(int'(cnt) + i) -: 32] <= col_out[i];
            cnt <= cnt + CNT_STEP;
        end
    end

`ifdef MIX_COLUMN_INV_EN
    // Mode is captured with the state so a late i_Inverse change cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               mode <= 1'b0;
        else if (state_q == IDLE && bus.i_Valid) mode <= bus.i_Inverse;
    end
`else
    assign mode = 1'b0;
`endif

endmodule
